// File: rtl/sal_ref_ctrl_if.sv
// Signal bundle between the refresh scheduler and its environment.
// The slave modport is the scheduler's view; master is the environment driving it.
interface sal_ref_ctrl_if #(
  parameter int TREFI_WIDTH = 16,
  parameter int MAX_PENDING = 8
) ();

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic                   init_done_i;
  logic [TREFI_WIDTH-1:0] t_refi_m1_i;
  logic                   ref_req_o;
  logic                   ref_gnt_i;
  logic                   block_req_o;
  logic [PW-1:0]          pending_cnt_o;
  logic                   ref_err_o;

  modport master (
    output init_done_i,
    output t_refi_m1_i,
    output ref_gnt_i,
    input  ref_req_o,
    input  block_req_o,
    input  pending_cnt_o,
    input  ref_err_o
  );

  modport slave (
    input  init_done_i,
    input  t_refi_m1_i,
    input  ref_gnt_i,
    output ref_req_o,
    output block_req_o,
    output pending_cnt_o,
    output ref_err_o
  );

endinterface

// File: rtl/sal_ref_ctrl.sv
// Refresh scheduler: tREFI interval ticks feed a postponed-refresh counter.
// Define SAL_REF_POSTPONE_EN to allow postponement up to MAX_PENDING refreshes.
module sal_ref_ctrl #(
  parameter int TREFI_WIDTH = 16,
  parameter int MAX_PENDING = 8,
  parameter int URGENT_TH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  sal_ref_ctrl_if.slave bus
);

  localparam int PW = $clog2(MAX_PENDING + 1);

`ifdef SAL_REF_POSTPONE_EN
  localparam bit POSTPONE = 1'b1;
`else
  localparam bit POSTPONE = 1'b0;
`endif

  // Without postponement every refresh is due at once, so the backlog limit is one.
  localparam int            EFF_MAX    = POSTPONE ? MAX_PENDING : 1;
  localparam int            EFF_URGENT = POSTPONE ? URGENT_TH : 1;
  localparam logic [PW-1:0] MAX_V      = PW'(EFF_MAX);
  localparam logic [PW-1:0] URGENT_V   = PW'(EFF_URGENT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [TREFI_WIDTH-1:0] cnt, cnt_nxt;
  logic [PW-1:0]          pending, pending_nxt;
  logic                   err, err_nxt;
  logic                   tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    err_nxt     = err;
    tick        = 1'b0;
    unique case (state)
      IDLE: begin
        pending_nxt = '0;
        if (bus.init_done_i) begin
          state_nxt = RUN;
          cnt_nxt   = bus.t_refi_m1_i;
        end
      end
      RUN: begin
        if (!bus.init_done_i) begin
          state_nxt   = IDLE;
          pending_nxt = '0;
        end else begin
          tick    = (cnt == '0);
          cnt_nxt = tick ? bus.t_refi_m1_i : cnt - TREFI_WIDTH'(1);
          // A tick and a grant in the same cycle cancel; a full backlog loses the obligation.
          if (tick && !bus.ref_gnt_i) begin
            if (pending == MAX_V) begin
              err_nxt = 1'b1;
            end else begin
              pending_nxt = pending + PW'(1);
            end
          end else if (!tick && bus.ref_gnt_i && (pending != '0)) begin
            pending_nxt = pending - PW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ref_req_o     = (pending != '0);
  assign bus.block_req_o   = (pending >= URGENT_V);
  assign bus.pending_cnt_o = pending;
  assign bus.ref_err_o     = err;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Self-checking bench for sal_ref_ctrl: vector table, drain sequence and
// randomized run against a time-based reference model.
module tb_sal_ref_ctrl;

`ifdef SAL_REF_POSTPONE_EN
  localparam bit ON = 1'b1;
`else
  localparam bit ON = 1'b0;
`endif

  localparam int M_MAX = ON ? 8 : 1;
  localparam int M_URG = ON ? 4 : 1;

  logic clk = 1'b0;
  logic rst_n;

  sal_ref_ctrl_if #(.TREFI_WIDTH(16), .MAX_PENDING(8)) bus ();

  sal_ref_ctrl #(
    .TREFI_WIDTH(16),
    .MAX_PENDING(8),
    .URGENT_TH  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit init;
    int trefi;
    bit gnt;
    int cycles;
    int pend;
    bit req;
    bit blk;
    bit err;
  } vec_t;

  vec_t vq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tick times are absolute cycle numbers, not a down-counter.
  longint cyc       = 0;
  longint next_tick = 0;
  int     m_pending = 0;
  bit     m_err     = 1'b0;
  bit     m_run     = 1'b0;

  function automatic vec_t mk(bit init, int trefi, bit gnt, int cycles,
                              int pend, bit req, bit blk, bit err);
    vec_t v;
    v.init = init; v.trefi = trefi; v.gnt = gnt; v.cycles = cycles;
    v.pend = pend; v.req = req; v.blk = blk; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit tick_now;
    if (!rst_n) begin
      m_pending = 0;
      m_err     = 1'b0;
      m_run     = 1'b0;
    end else if (!m_run) begin
      m_pending = 0;
      if (bus.init_done_i) begin
        m_run     = 1'b1;
        next_tick = cyc + longint'(bus.t_refi_m1_i) + 1;
      end
    end else if (!bus.init_done_i) begin
      m_run     = 1'b0;
      m_pending = 0;
    end else begin
      tick_now = (cyc == next_tick);
      if (tick_now) next_tick = cyc + longint'(bus.t_refi_m1_i) + 1;
      if (tick_now && !bus.ref_gnt_i) begin
        if (m_pending == M_MAX) m_err = 1'b1;
        else m_pending++;
      end else if (!tick_now && bus.ref_gnt_i && m_pending > 0) begin
        m_pending--;
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pending"}, 32'(bus.pending_cnt_o), 32'(m_pending));
    check({tag, " req"},     32'(bus.ref_req_o),     32'(m_pending != 0));
    check({tag, " block"},   32'(bus.block_req_o),   32'(m_pending >= M_URG));
    check({tag, " err"},     32'(bus.ref_err_o),     32'(m_err));
  endtask

  task automatic check_outputs(input string tag, input int pend, input bit req,
                               input bit blk, input bit err);
    check({tag, " pending"}, 32'(bus.pending_cnt_o), 32'(pend));
    check({tag, " req"},     32'(bus.ref_req_o),     32'(req));
    check({tag, " block"},   32'(bus.block_req_o),   32'(blk));
    check({tag, " err"},     32'(bus.ref_err_o),     32'(err));
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.init_done_i = v.init;
    bus.t_refi_m1_i = 16'(v.trefi);
    bus.ref_gnt_i   = v.gnt;
    repeat (v.cycles) tick_cycle();
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check_outputs($sformatf("vec%0d", idx), v.pend, v.req, v.blk, v.err);
  endtask

  initial begin
    int exp_p;
    int gthr;

    // Ticks every 10 cycles from reset, then tick+grant, grant, init drop, re-raise with tREFI=5.
    vq.push_back(mk(0, 9, 0,  2, 0, 0, 0, 0));
    vq.push_back(mk(1, 9, 0,  1, 0, 0, 0, 0));
    vq.push_back(mk(1, 9, 0,  9, 0, 0, 0, 0));
    vq.push_back(mk(1, 9, 0,  1, 1, 1, !ON, 0));
    vq.push_back(mk(1, 9, 0, 10, ON ? 2 : 1, 1, !ON, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 3 : 1, 1, !ON, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 4 : 1, 1, 1, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 5 : 1, 1, 1, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 6 : 1, 1, 1, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 7 : 1, 1, 1, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 8 : 1, 1, 1, !ON));
    vq.push_back(mk(1, 9, 0, 10, ON ? 8 : 1, 1, 1, 1));
    vq.push_back(mk(1, 9, 0, 10, ON ? 8 : 1, 1, 1, 1));
    vq.push_back(mk(1, 9, 0,  9, ON ? 8 : 1, 1, 1, 1));
    vq.push_back(mk(1, 9, 1,  1, ON ? 8 : 1, 1, 1, 1));
    vq.push_back(mk(1, 9, 1,  1, ON ? 7 : 0, ON, ON, 1));
    vq.push_back(mk(1, 9, 0,  1, ON ? 7 : 0, ON, ON, 1));
    vq.push_back(mk(0, 9, 0,  1, 0, 0, 0, 1));
    vq.push_back(mk(0, 4, 0,  3, 0, 0, 0, 1));
    vq.push_back(mk(1, 4, 0,  1, 0, 0, 0, 1));
    vq.push_back(mk(1, 4, 0,  4, 0, 0, 0, 1));
    vq.push_back(mk(1, 4, 0,  1, 1, 1, !ON, 1));
    vq.push_back(mk(1, 4, 0,  5, ON ? 2 : 1, 1, !ON, 1));

    rst_n           = 1'b0;
    bus.init_done_i = 1'b0;
    bus.t_refi_m1_i = 16'd9;
    bus.ref_gnt_i   = 1'b0;
    repeat (2) tick_cycle();
    check_outputs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i]);
      checkOutput(i, vq[i]);
    end

    // Reset while running with a backlog and a sticky error.
    rst_n = 1'b0;
    tick_cycle();
    check_outputs("midreset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Drain: build a backlog of five, stretch tREFI, then grant every third cycle.
    bus.init_done_i = 1'b1;
    bus.t_refi_m1_i = 16'd2;
    bus.ref_gnt_i   = 1'b0;
    repeat (13) begin
      tick_cycle();
      check_model("build");
    end
    bus.t_refi_m1_i = 16'd60000;
    repeat (3) begin
      tick_cycle();
      check_model("build");
    end
    check_outputs("drain start", ON ? 5 : 1, 1, 1, !ON);
    for (int k = 1; k <= 5; k++) begin
      bus.ref_gnt_i = 1'b1;
      tick_cycle();
      exp_p = ON ? 5 - k : 0;
      check_outputs($sformatf("drain%0d", k), exp_p, exp_p != 0, exp_p >= 4, !ON);
      bus.ref_gnt_i = 1'b0;
      repeat (2) begin
        tick_cycle();
        check_model("drain gap");
      end
    end
    bus.ref_gnt_i = 1'b1;
    tick_cycle();
    check_outputs("stray grant", 0, 0, 0, !ON);
    bus.ref_gnt_i = 1'b0;

    // Randomized run: grants only while a refresh is outstanding, rate varied per epoch.
    rst_n = 1'b0;
    tick_cycle();
    rst_n = 1'b1;
    gthr  = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) gthr = $urandom_range(0, 4);
      rst_n           = ($urandom_range(0, 499) != 0);
      bus.init_done_i = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 39) == 0) bus.t_refi_m1_i = 16'($urandom_range(0, 12));
      bus.ref_gnt_i   = (m_pending > 0) && ($urandom_range(0, 9) < gthr);
      tick_cycle();
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
